// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//
// Round-robin scheduler that lets NUM_REQ byte producers share a single
// uart_if transmit channel. One byte is issued per UART frame: the winner's
// byte is placed on tx_data_o together with a 1-clk tx_irq_o pulse and a 1-clk
// ack_o pulse back to the winner. The block then follows tx_busy_i through the
// frame before arbitrating again. If tx_busy_i never rises within BUSY_TO
// cycles after the irq, err_o pulses and the block returns to idle.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   req_i        per-requester level request, held with its byte until ack
//   data_i       byte of requester k on bits [8k+7:8k]
//   ack_o        1-clk pulse, byte of requester k has been issued
//   tx_irq_o     1-clk pulse to uart_if tx_irq_i
//   tx_data_o    byte to uart_if tx_data_i, stable for the whole frame
//   tx_busy_i    uart_if tx_busy_o
//   grant_idx_o  index of the last granted requester
//   active_o     high while a frame is being tracked (not idle)
//   err_o        1-clk pulse when tx_busy_i fails to rise in time
// ---------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int BUSY_TO = 15,
  parameter int TO_W    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [8*NUM_REQ-1:0] data_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic                 tx_irq_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_busy_i,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 active_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  localparam logic [TO_W-1:0]  BUSY_TO_C = TO_W'(BUSY_TO);
  // Pointer starts at the last requester so requester 0 is searched first.
  localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(NUM_REQ - 1);

  state_e               state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [TO_W-1:0]      cnt_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 tx_irq_q;
  logic [7:0]           tx_data_q;
  logic [IDX_W-1:0]     grant_idx_q;
  logic                 active_q;
  logic                 err_q;

  logic [7:0]           req_byte [NUM_REQ];
  logic                 grant_vld_d;
  logic [IDX_W-1:0]     grant_idx_d;
  logic [IDX_W-1:0]     cand_idx;
  logic [NUM_REQ-1:0]   ack_d;
  logic [7:0]           tx_data_d;

  // Per-requester byte lanes and one-hot ack decode of the candidate winner.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign req_byte[gi] = data_i[8*gi +: 8];
      assign ack_d[gi]    = (grant_idx_d == IDX_W'(gi));
    end
  endgenerate

  // Round-robin search starting at ptr+1. The loop walks the search order
  // backwards so the earliest set request in that order is written last and
  // therefore wins, without needing an early exit.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_idx_d = '0;
    cand_idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req_i[cand_idx]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = cand_idx;
      end
    end
  end

  assign tx_data_d = req_byte[grant_idx_d];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PTR_RST;
      cnt_q       <= '0;
      ack_q       <= '0;
      tx_irq_q    <= 1'b0;
      tx_data_q   <= 8'h00;
      grant_idx_q <= '0;
      active_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Pulse outputs default low; only the branches below raise them.
      ack_q    <= '0;
      tx_irq_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A busy channel in idle belongs to someone else (or a stale
          // frame); hold all requests until it clears.
          if (grant_vld_d && !tx_busy_i) begin
            tx_data_q   <= tx_data_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= grant_idx_d;
            tx_irq_q    <= 1'b1;
            ack_q       <= ack_d;
            cnt_q       <= '0;
            active_q    <= 1'b1;
            state_q     <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          // Busy rising takes priority over the timeout on the same edge.
          if (tx_busy_i) begin
            state_q <= ST_WAIT_DONE;
          end else if (cnt_q == BUSY_TO_C) begin
            err_q    <= 1'b1;
            active_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy_i) begin
            active_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          active_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_o       = ack_q;
  assign tx_irq_o    = tx_irq_q;
  assign tx_data_o   = tx_data_q;
  assign grant_idx_o = grant_idx_q;
  assign active_o    = active_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
//
// Directed and randomized bench for uart_tx_arb. The bench plays both the
// requesters and the uart_if busy line. Expected grants come from a
// transaction-level round-robin rule (first set request after the last
// winner, wrapping), and expected timing from the frame handshake rules:
// grant one clock after the request is seen in idle, busy rising ends the
// wait, busy falling returns to idle, busy absent for BUSY_TO counts errors.
// ---------------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int BUSY_TO = 15;
  localparam int TO_W    = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] data;
  logic [NUM_REQ-1:0]   ack;
  logic                 tx_irq;
  logic [7:0]           tx_data;
  logic                 busy;
  logic [IDX_W-1:0]     grant_idx;
  logic                 active;
  logic                 err;

  int tests = 0;
  int fails = 0;
  int ptr_m;                 // last winner according to the model
  logic [7:0] last_byte_m;   // byte expected on tx_data_o between grants

  uart_tx_arb #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W),
    .BUSY_TO(BUSY_TO),
    .TO_W   (TO_W)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .data_i     (data),
    .ack_o      (ack),
    .tx_irq_o   (tx_irq),
    .tx_data_o  (tx_data),
    .tx_busy_i  (busy),
    .grant_idx_o(grant_idx),
    .active_o   (active),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // Round-robin rule: first requester set after p, wrapping; -1 if none.
  function automatic int next_grant(input logic [NUM_REQ-1:0] r, input int p);
    int idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (p + k) % NUM_REQ;
      if (((int'(r) >> idx) & 1) == 1) return idx;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string where);
    check({where, "_ack"},    32'(ack),       0);
    check({where, "_irq"},    32'(tx_irq),    0);
    check({where, "_data"},   32'(tx_data),   0);
    check({where, "_gidx"},   32'(grant_idx), 0);
    check({where, "_active"}, 32'(active),    0);
    check({where, "_err"},    32'(err),       0);
  endtask

  task automatic idle_ticks(input int n, input string where);
    for (int i = 0; i < n; i++) begin
      tick();
      check({where, "_irq"},    32'(tx_irq),  0);
      check({where, "_ack"},    32'(ack),     0);
      check({where, "_active"}, 32'(active),  0);
      check({where, "_err"},    32'(err),     0);
      check({where, "_data"},   32'(tx_data), 32'(last_byte_m));
    end
  endtask

  // One complete frame: arbitration in the current idle cycle, busy rising
  // d clocks after the irq cycle, busy high for len clocks. mid_req is
  // applied just after busy is seen, late_req on the last busy clock; both
  // land while the frame is in progress and must not affect it.
  task automatic frame(input int d, input int len, input logic [NUM_REQ-1:0] mid_req,
                       input logic [NUM_REQ-1:0] late_req, input string label, output int g);
    logic [7:0] b;
    g = next_grant(req, ptr_m);
    b = 8'h00;
    if (g >= 0) b = data[8*g +: 8];
    tick();
    if (g < 0) begin
      check({label, "_noreq_irq"}, 32'(tx_irq), 0);
    end else begin
      check({label, "_irq"},    32'(tx_irq),    1);
      check({label, "_ack"},    32'(ack),       1 << g);
      check({label, "_data"},   32'(tx_data),   32'(b));
      check({label, "_gidx"},   32'(grant_idx), g);
      check({label, "_active"}, 32'(active),    1);
      check({label, "_err"},    32'(err),       0);
      ptr_m       = g;
      last_byte_m = b;
      $display("[TB] %s: grant=%0d byte=%02h busy_delay=%0d busy_len=%0d", label, g, b, d, len);
      for (int i = 0; i < d; i++) begin
        tick();
        check({label, "_wb_irq"},    32'(tx_irq),  0);
        check({label, "_wb_ack"},    32'(ack),     0);
        check({label, "_wb_active"}, 32'(active),  1);
        check({label, "_wb_err"},    32'(err),     0);
        check({label, "_wb_data"},   32'(tx_data), 32'(b));
      end
      busy = 1'b1;
      for (int i = 0; i < len; i++) begin
        tick();
        if (i == 0) req = mid_req;
        if (i == len - 1) req = late_req;
        check({label, "_wd_irq"},    32'(tx_irq),  0);
        check({label, "_wd_ack"},    32'(ack),     0);
        check({label, "_wd_active"}, 32'(active),  1);
        check({label, "_wd_err"},    32'(err),     0);
        check({label, "_wd_data"},   32'(tx_data), 32'(b));
      end
      busy = 1'b0;
      tick();
      check({label, "_end_active"}, 32'(active),  0);
      check({label, "_end_irq"},    32'(tx_irq),  0);
      check({label, "_end_err"},    32'(err),     0);
      check({label, "_end_data"},   32'(tx_data), 32'(b));
    end
  endtask

  initial begin
    int g;
    int exp_order [5];
    logic [7:0] b;

    rst_n = 1'b0;
    req   = '0;
    data  = '0;
    busy  = 1'b0;
    ptr_m = NUM_REQ - 1;
    last_byte_m = 8'h00;
    exp_order = '{0, 1, 2, 3, 0};

    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle_ticks(2, "post_reset_idle");

    // All four requesters held: strict rotation starting at requester 0.
    req  = 4'b1111;
    data = 32'h13121110;
    for (int i = 0; i < 5; i++) begin
      frame(3, 8, 4'b1111, 4'b1111, "all4", g);
      check("all4_order", g, exp_order[i]);
    end

    // Single requester 2, long frame, drops its request after the ack.
    req  = 4'b0100;
    data = 32'h00A50000;
    frame(3, 40, 4'b0000, 4'b0000, "single", g);
    check("single_grant", g, 2);
    idle_ticks(3, "single_idle");

    // Busy never rises: error exactly BUSY_TO+1 clocks after the irq cycle.
    req  = 4'b0001;
    data = 32'h0000007E;
    g = next_grant(req, ptr_m);
    b = data[8*g +: 8];
    tick();
    check("to_grant_irq", 32'(tx_irq), 1);
    check("to_grant_ack", 32'(ack),    1 << g);
    check("to_grant_idx", g, 0);
    ptr_m       = g;
    last_byte_m = b;
    req = 4'b0000;
    $display("[TB] timeout: grant=%0d byte=%02h busy never rises", g, b);
    for (int i = 1; i <= BUSY_TO + 1; i++) begin
      tick();
      check("to_err",    32'(err),     32'(i == BUSY_TO + 1));
      check("to_active", 32'(active),  32'(i <= BUSY_TO));
      check("to_irq",    32'(tx_irq),  0);
      check("to_data",   32'(tx_data), 32'(b));
    end
    idle_ticks(2, "to_idle");
    req  = 4'b0010;
    data = 32'h0000C300;
    frame(0, 5, 4'b0000, 4'b0000, "after_timeout", g);
    check("after_timeout_grant", g, 1);

    // Busy rising on the very last allowed count is not a timeout.
    req  = 4'b0100;
    data = 32'h003C0000;
    frame(BUSY_TO, 4, 4'b0000, 4'b0000, "busy_at_limit", g);
    check("busy_at_limit_grant", g, 2);

    // Foreign busy in idle blocks arbitration; release grants next clock.
    req  = 4'b0001;
    data = 32'h0000005A;
    busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("busy_block_irq",    32'(tx_irq), 0);
      check("busy_block_ack",    32'(ack),    0);
      check("busy_block_active", 32'(active), 0);
    end
    busy = 1'b0;
    frame(2, 6, 4'b0000, 4'b0000, "busy_release", g);
    check("busy_release_grant", g, 0);

    // Requesters 1 and 3 raise during a frame; 1 drops before idle.
    req  = 4'b0001;
    data = 32'h99000077;
    frame(1, 6, 4'b1010, 4'b1000, "drop_pre", g);
    check("drop_pre_grant", g, 0);
    frame(1, 4, 4'b0000, 4'b0000, "drop_next", g);
    check("drop_next_grant", g, 3);

    // Reset in the middle of a frame.
    req  = 4'b0100;
    data = 32'h005C0000;
    g = next_grant(req, ptr_m);
    tick();
    check("rst_pre_irq",  32'(tx_irq), 1);
    check("rst_pre_gidx", g, 2);
    busy = 1'b1;
    tick();
    tick();
    req = 4'b0000;
    check("rst_pre_active", 32'(active), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    busy = 1'b0;
    req  = 4'b1000;
    data[31:24] = 8'($urandom);
    tick();
    check_reset_outputs("rst_held");
    rst_n       = 1'b1;
    ptr_m       = NUM_REQ - 1;
    last_byte_m = 8'h00;
    $display("[TB] reset mid-frame: outputs cleared, requester 3 pending with byte %02h", data[31:24]);
    frame(2, 5, 4'b0000, 4'b0000, "after_reset", g);
    check("after_reset_grant", g, 3);

    // Randomized frames against the round-robin rule.
    for (int n = 0; n < 20; n++) begin
      req  = 4'($urandom_range(1, 15));
      data = $urandom;
      frame(int'($urandom_range(0, BUSY_TO)), int'($urandom_range(1, 10)),
            4'($urandom), 4'($urandom), "rand", g);
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        idle_ticks(int'($urandom_range(1, 3)), "rand_idle");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
